// File: rtl/seg7_scan_bcd.sv
// Four-digit common-anode 7-segment scanner with frame-coherent snapshot,
// anti-ghosting dead time, leading-zero blanking and per-digit blink.
module seg7_scan_bcd #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD      = 500,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  input  logic [3:0] blink_mask,
  input  logic       lz_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    dpm_q, dpm_d;
  logic [3:0]    bm_q, bm_d;
  logic          lz_q, lz_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          slot_tick;
  logic          wrap;
  logic [3:0]    cur;
  logic [3:0]    blank;
  logic          off;

  always_comb begin
    slot_tick = (cnt_q == CW'(SCAN_DIV - 1));
    wrap      = slot_tick && (idx_q == 2'd3);
    cnt_d     = slot_tick ? '0 : cnt_q + 1'b1;
    idx_d     = slot_tick ? idx_q + 2'd1 : idx_q;

    // Inputs are captured only at the frame boundary so a frame never tears.
    snap_d  = wrap ? {d3, d2, d1, d0} : snap_q;
    dpm_d   = wrap ? dp_in : dpm_q;
    bm_d    = wrap ? blink_mask : bm_q;
    lz_d    = wrap ? lz_en : lz_q;

    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (int'(frm_q) == BLINK_DIV - 1) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    blank[3] = lz_q && (snap_q[15:12] == 4'd0);
    blank[2] = blank[3] && (snap_q[11:8] == 4'd0);
    blank[1] = blank[2] && (snap_q[7:4] == 4'd0);
    blank[0] = 1'b0;

    cur  = snap_q[{idx_q, 2'b00} +: 4];
    off  = blank[idx_q] | (bm_q[idx_q] & phase_q);
    // An off digit keeps its anode so every digit gets the same duty cycle.
    seg_d = off ? 7'h7F : ~seg_decode(cur);
    dp_d  = off ? 1'b1 : ~dpm_q[idx_q];
    an_d  = (int'(cnt_q) < DEAD) ? 4'hF : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      snap_q  <= '0;
      dpm_q   <= '0;
      bm_q    <= '0;
      lz_q    <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 4'hF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      dpm_q   <= dpm_d;
      bm_q    <= bm_d;
      lz_q    <= lz_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
